// File: rtl/wb_fifo_pkg.sv
// Shared sizing helpers and threshold range checks for the level-tracking Wishbone FIFO.
package wb_fifo_pkg;

  localparam int AFULL_MIN  = 1;
  localparam int AEMPTY_MIN = 0;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic int lvl_width(input int aw);
    return aw + 1;
  endfunction

  function automatic bit afull_lvl_ok(input int aw, input int lvl);
    return (lvl >= AFULL_MIN) && (lvl <= fifo_depth(aw));
  endfunction

  function automatic bit aempty_lvl_ok(input int aw, input int lvl);
    return (lvl >= AEMPTY_MIN) && (lvl < fifo_depth(aw));
  endfunction

endpackage

// File: rtl/wb_fifo_lvl_if.sv
// Push and pop Wishbone handshakes of the FIFO, bundled as one bus.
interface wb_fifo_lvl_if #(parameter int DW = 8) ();
  logic          i_wb_push_cyc;
  logic          i_wb_push_stb;
  logic [DW-1:0] i_wb_push_data;
  logic          o_wb_push_stall;
  logic          o_wb_push_ack;
  logic          i_wb_pop_cyc;
  logic          i_wb_pop_stb;
  logic          o_wb_pop_stall;
  logic          o_wb_pop_ack;
  logic [DW-1:0] o_wb_pop_data;

  modport slave (
    input  i_wb_push_cyc, i_wb_push_stb, i_wb_push_data,
    output o_wb_push_stall, o_wb_push_ack,
    input  i_wb_pop_cyc, i_wb_pop_stb,
    output o_wb_pop_stall, o_wb_pop_ack, o_wb_pop_data
  );

  modport master (
    output i_wb_push_cyc, i_wb_push_stb, i_wb_push_data,
    input  o_wb_push_stall, o_wb_push_ack,
    output i_wb_pop_cyc, i_wb_pop_stb,
    input  o_wb_pop_stall, o_wb_pop_ack, o_wb_pop_data
  );
endinterface

// File: rtl/wb_fifo_ptr.sv
// Wrapping AW-bit FIFO pointer; flush beats increment.
module wb_fifo_ptr #(
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_flush,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_flush)    ptr_d = '0;
    else if (i_inc) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign o_ptr = ptr_q;
endmodule

// File: rtl/wb_fifo_lvl.sv
// Wishbone FIFO over an external sync dual-port RAM; full depth usable, level-based
// flags, simultaneous push/pop, synchronous flush and sticky error flags.
module wb_fifo_lvl
  import wb_fifo_pkg::*;
#(
  parameter int DW         = 8,
  parameter int AW         = 5,
  parameter int AFULL_LVL  = (1 << AW) - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_flush,
  wb_fifo_lvl_if.slave  bus,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_afull,
  output logic          o_aempty,
  output logic [AW:0]   o_level,
  output logic          o_overflow,
  output logic          o_underflow,
  output logic [AW-1:0] mem_addr_w,
  output logic          mem_we,
  output logic [DW-1:0] mem_data_write,
  output logic [AW-1:0] mem_addr_r,
  input  logic [DW-1:0] mem_data_read
);
  localparam int            LW       = lvl_width(AW);
  localparam logic [LW-1:0] FULL_L   = LW'(fifo_depth(AW));
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

  if (!afull_lvl_ok(AW, AFULL_LVL)) begin : g_bad_afull
    $error("wb_fifo_lvl: AFULL_LVL out of range");
  end
  if (!aempty_lvl_ok(AW, AEMPTY_LVL)) begin : g_bad_aempty
    $error("wb_fifo_lvl: AEMPTY_LVL out of range");
  end

  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push_ack_q, push_ack_d, pop_ack_q, pop_ack_d;
  logic          push_req, pop_req, push_ok, pop_ok;
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Flags come from the level, so wr_ptr == rd_ptr is never ambiguous.
  assign o_full   = (lvl_q == FULL_L);
  assign o_empty  = (lvl_q == '0);
  assign o_afull  = (lvl_q >= AFULL_L);
  assign o_aempty = (lvl_q <= AEMPTY_L);
  assign o_level  = lvl_q;

  assign push_req = bus.i_wb_push_cyc & bus.i_wb_push_stb;
  assign pop_req  = bus.i_wb_pop_cyc & bus.i_wb_pop_stb;
  assign push_ok  = push_req & ~o_full;
  assign pop_ok   = pop_req & ~o_empty;

  wb_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_inc(push_ok), .o_ptr(wr_ptr)
  );
  wb_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_inc(pop_ok), .o_ptr(rd_ptr)
  );

  assign mem_we         = push_ok;
  assign mem_addr_w     = wr_ptr;
  assign mem_data_write = bus.i_wb_push_data;
  assign mem_addr_r     = rd_ptr;

  assign bus.o_wb_push_stall = o_full;
  assign bus.o_wb_push_ack   = push_ack_q;
  assign bus.o_wb_pop_stall  = o_empty;
  assign bus.o_wb_pop_ack    = pop_ack_q;
  assign bus.o_wb_pop_data   = mem_data_read;

  always_comb begin
    lvl_d      = lvl_q;
    ovf_d      = ovf_q | (push_req & o_full);
    unf_d      = unf_q | (pop_req & o_empty);
    push_ack_d = push_ok & ~i_flush;
    pop_ack_d  = pop_ok & ~i_flush;
    if (i_flush) begin
      lvl_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (push_ok && !pop_ok) begin
      lvl_d = lvl_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      lvl_d = lvl_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lvl_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      push_ack_q <= 1'b0;
      pop_ack_q  <= 1'b0;
    end else begin
      lvl_q      <= lvl_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      push_ack_q <= push_ack_d;
      pop_ack_q  <= pop_ack_d;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
endmodule

// File: tb/tb_wb_fifo_lvl.sv
// Random and directed stimulus for wb_fifo_lvl (depth 4) checked against a queue model.
module tb_wb_fifo_lvl;
  localparam int DW = 8, AW = 2, DEPTH = 4, AFL = 3, AEL = 1;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  wb_fifo_lvl_if #(.DW(DW)) bus ();

  logic          full, empty, afull, aempty, ovf, unf, mem_we;
  logic [AW:0]   level;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;
  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  wb_fifo_lvl #(.DW(DW), .AW(AW), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .bus(bus),
    .o_full(full), .o_empty(empty), .o_afull(afull), .o_aempty(aempty),
    .o_level(level), .o_overflow(ovf), .o_underflow(unf),
    .mem_addr_w(waddr), .mem_we(mem_we), .mem_data_write(wdata),
    .mem_addr_r(raddr), .mem_data_read(rdata)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, flags as plain booleans.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 0, m_unf = 0, m_pack = 0, m_qack = 0;
  logic [DW-1:0] m_qdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_pack = 0; m_qack = 0;
    end else begin
      bit preq, qreq, pok, qok;
      preq = bus.i_wb_push_cyc && bus.i_wb_push_stb;
      qreq = bus.i_wb_pop_cyc && bus.i_wb_pop_stb;
      pok  = preq && (mq.size() < DEPTH);
      qok  = qreq && (mq.size() > 0);
      m_pack = pok && !flush;
      m_qack = qok && !flush;
      if (qok && !flush) m_qdata = mq[0];
      if (flush) begin
        mq.delete();
        m_ovf = 0; m_unf = 0;
      end else begin
        if (preq && mq.size() == DEPTH) m_ovf = 1;
        if (qreq && mq.size() == 0)     m_unf = 1;
        if (qok) void'(mq.pop_front());
        if (pok) mq.push_back(bus.i_wb_push_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int sz;
      sz = mq.size();
      chk("level", level, sz);
      chk("full", full, sz == DEPTH);
      chk("empty", empty, sz == 0);
      chk("afull", afull, sz >= AFL);
      chk("aempty", aempty, sz <= AEL);
      chk("push_stall", bus.o_wb_push_stall, sz == DEPTH);
      chk("pop_stall", bus.o_wb_pop_stall, sz == 0);
      chk("overflow", ovf, m_ovf);
      chk("underflow", unf, m_unf);
      chk("push_ack", bus.o_wb_push_ack, m_pack);
      chk("pop_ack", bus.o_wb_pop_ack, m_qack);
      if (m_qack) chk("pop_data", bus.o_wb_pop_data, m_qdata);
      chk("mem_we", mem_we, bus.i_wb_push_cyc && bus.i_wb_push_stb && sz < DEPTH);
      if (mem_we) chk("mem_wdata", wdata, bus.i_wb_push_data);
    end
  end

  // One clock cycle with the given requests; returns 1 time unit after the edge.
  task automatic step(input bit pc, input bit ps, input bit qc, input bit qs,
                      input logic [DW-1:0] d, input bit fl);
    bus.i_wb_push_cyc  = pc;
    bus.i_wb_push_stb  = ps;
    bus.i_wb_push_data = d;
    bus.i_wb_pop_cyc   = qc;
    bus.i_wb_pop_stb   = qs;
    flush              = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit push, input bit pop, input logic [DW-1:0] d, input bit fl);
    step(push, push, pop, pop, d, fl);
  endtask

  initial begin
    bit lv_af[5];
    bit lv_ae[5];
    lv_af = '{0, 0, 0, 1, 1};
    lv_ae = '{1, 1, 0, 0, 0};
    bus.i_wb_push_cyc = 0; bus.i_wb_push_stb = 0; bus.i_wb_push_data = '0;
    bus.i_wb_pop_cyc = 0;  bus.i_wb_pop_stb = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);

    // Fill to full, checking threshold flags at each level.
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 8'hA1 + 8'(i), 0);
      chk("fill_ack", bus.o_wb_push_ack, 1);
      chk("fill_level", level, i + 1);
      chk("fill_afull", afull, lv_af[i+1]);
      chk("fill_aempty", aempty, lv_ae[i+1]);
    end
    chk("full_flag", full, 1);
    chk("full_stall", bus.o_wb_push_stall, 1);

    op(1, 0, 8'h55, 0);
    chk("ovf_noack", bus.o_wb_push_ack, 0);
    chk("ovf_flag", ovf, 1);
    chk("ovf_level", level, 4);

    // Drain; data in order, one cycle after each strobe.
    for (int i = 0; i < 4; i++) begin
      op(0, 1, 8'h00, 0);
      chk("drain_ack", bus.o_wb_pop_ack, 1);
      chk("drain_data", bus.o_wb_pop_data, 8'hA1 + 8'(i));
      chk("drain_afull", afull, lv_af[3-i]);
      chk("drain_aempty", aempty, lv_ae[3-i]);
    end
    chk("drain_empty", empty, 1);

    // Push and pop into empty: pop refused, push taken.
    op(1, 1, 8'h77, 0);
    chk("unf_popack", bus.o_wb_pop_ack, 0);
    chk("unf_pushack", bus.o_wb_push_ack, 1);
    chk("unf_flag", unf, 1);
    chk("unf_level", level, 1);
    op(0, 1, 8'h00, 0);
    chk("unf_pop_ack", bus.o_wb_pop_ack, 1);
    chk("unf_pop_data", bus.o_wb_pop_data, 8'h77);

    // Hold level 2 with simultaneous traffic across the pointer wrap.
    op(1, 0, 8'hB0, 0);
    op(1, 0, 8'hB1, 0);
    for (int i = 0; i < 6; i++) begin
      op(1, 1, 8'hC0 + 8'(i), 0);
      chk("simul_level", level, 2);
      chk("simul_ack", bus.o_wb_pop_ack, 1);
      chk("simul_data", bus.o_wb_pop_data, (i < 2) ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - 2));
    end

    // Full with simultaneous push+pop: pop wins, level 3.
    op(1, 0, 8'hD0, 0);
    op(1, 0, 8'hD1, 0);
    op(1, 1, 8'hD2, 0);
    chk("fullsim_level", level, 3);
    chk("fullsim_pushack", bus.o_wb_push_ack, 0);
    chk("fullsim_ovf", ovf, 1);

    // Flush with a push in the same cycle.
    op(1, 0, 8'h99, 1);
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", ovf, 0);
    chk("flush_unf", unf, 0);
    chk("flush_noack", bus.o_wb_push_ack, 0);

    // Reset while a pop ack is in flight.
    op(1, 0, 8'h3C, 0);
    op(1, 0, 8'h3D, 0);
    op(0, 1, 8'h00, 0);
    chk("pre_rst_ack", bus.o_wb_pop_ack, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ack_drop", bus.o_wb_pop_ack, 0);
    chk("rst_level_drop", level, 0);
    bus.i_wb_pop_cyc = 0; bus.i_wb_pop_stb = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized phases: push-heavy, pop-heavy, balanced; occasional flush.
    for (int i = 0; i < 3000; i++) begin
      int pp;
      bit pc, ps, qc, qs, fl;
      case ((i / 60) % 3)
        0:       pp = 80;
        1:       pp = 20;
        default: pp = 50;
      endcase
      pc = ($urandom_range(0, 99) < 90);
      ps = ($urandom_range(0, 99) < pp);
      qc = ($urandom_range(0, 99) < 90);
      qs = ($urandom_range(0, 99) < 100 - pp);
      fl = ($urandom_range(0, 99) < 2);
      step(pc, ps, qc, qs, 8'($urandom), fl);
    end
    op(0, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_fifo_lvl.md
Name: wb_fifo_lvl

Overview:
Second-generation Wishbone FIFO with an external synchronous dual-port memory. Compared with the first-generation FIFO, it uses all 2^AW entries, not 2^AW-1, and accepts push and pop in the same cycle. It also adds a fill-level output, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between UART/bus peripherals and the Z80-side bus glue, wherever buffering needs level-based flow control.

Parameters:
DW, 8, data word width.
AW, 5, memory address width; depth = 2^AW entries.
AFULL_LVL, 2^AW-4, o_afull asserts when level >= AFULL_LVL (1..2^AW).
AEMPTY_LVL, 4, o_aempty asserts when level <= AEMPTY_LVL (0..2^AW-1).

Ports:
i_clk  in  1  system clock.
i_reset_n  in  1  reset; asynchronous assert, active-low.
i_flush  in  1  synchronous clear of pointers, level and error flags.
i_wb_push_cyc  in  1  push bus cycle; a strobe counts only when cyc is also high.
i_wb_push_stb  in  1  push request, one word per cycle.
i_wb_push_data  in  DW  push data.
o_wb_push_stall  out  1  push back-pressure; equals o_full.
o_wb_push_ack  out  1  push accepted, registered.
i_wb_pop_cyc  in  1  pop bus cycle.
i_wb_pop_stb  in  1  pop request.
o_wb_pop_stall  out  1  pop back-pressure; equals o_empty.
o_wb_pop_ack  out  1  pop data valid.
o_wb_pop_data  out  DW  popped word; valid only while ack is high.
o_full  out  1  level == 2^AW.
o_empty  out  1  level == 0.
o_afull  out  1  almost full.
o_aempty  out  1  almost empty.
o_level  out  AW+1  current occupancy.
o_overflow  out  1  sticky: push strobe seen while full.
o_underflow  out  1  sticky: pop strobe seen while empty.
mem_addr_w  out  AW  memory write address.
mem_we  out  1  memory write enable.
mem_data_write  out  DW  memory write data.
mem_addr_r  out  AW  memory read address.
mem_data_read  in  DW  memory read data; synchronous, one-cycle latency.

Behaviour:
- Reset (asynchronous, i_reset_n low): pointers, level, both acks, o_overflow and o_underflow all go to 0. Status flags follow the level combinationally: o_empty=1, o_aempty=1, o_full=0, o_afull=0. Reset mid-operation drops any in-flight ack.
- Acceptance (combinational in cycle N):
  - push_ok = i_wb_push_cyc & i_wb_push_stb & !o_full
  - pop_ok = i_wb_pop_cyc & i_wb_pop_stb & !o_empty
  - Both use the flags as they stand at the start of the cycle. There is no fall-through: a push into an empty FIFO plus a pop in the same cycle gives pop rejected, push accepted.
- Push path:
  - mem_we = push_ok, mem_addr_w = wr_ptr and mem_data_write = i_wb_push_data, all combinational in cycle N.
  - Memory writes at the end of N; wr_ptr increments at the same edge.
  - o_wb_push_ack = 1 in N+1.
- Pop path:
  - mem_addr_r = rd_ptr, combinational.
  - On pop_ok in cycle N, rd_ptr increments at the end of N.
  - In N+1: o_wb_pop_ack = 1 and o_wb_pop_data = mem_data_read, which is the word addressed in N.
  - A word pushed in N is poppable from N+1 and its data appears in N+2.
- Pointers: AW bits, natural wrap from 2^AW-1 to 0.
- Level: AW+1 bits.
  - +1 on push_ok only; -1 on pop_ok only; unchanged when both occur.
  - Full/empty are derived from level, so pointer equality is never ambiguous.
  - Level never exceeds 2^AW and never goes below 0.
- Simultaneous push and pop when full: pop accepted, push stalled (push_ok uses the current o_full). Next cycle the level is 2^AW-1.
- Errors:
  - o_overflow sets on cyc & push strobe while o_full.
  - o_underflow sets on cyc & pop strobe while o_empty.
  - Both stay set until i_flush or reset.
- Flush: on the next edge, pointers, level and error flags clear. Any push_ok/pop_ok in the flush cycle is discarded, and no ack is issued for it. Flush takes priority over everything.
- Strobes are single-cycle requests. A stalled request is not retried; the master must reissue it.

Decomposition:
- Package wb_fifo_pkg holds:
  - the depth function (2^AW);
  - the level width (AW+1);
  - the threshold-range localparams and elaboration checks: AFULL_LVL in 1..2^AW, AEMPTY_LVL < 2^AW.
- One sub-module, wb_fifo_ptr: an AW-bit pointer register with increment enable, flush and asynchronous reset. It is instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
- AW=2 (depth 4): reset, then push 0xA1,0xA2,0xA3,0xA4 -> each push ack one cycle later; after the last, o_full=1, o_level=4, push_stall=1.
- Full, then push 0x55 -> no ack, o_overflow=1, level stays 4. Pop four times -> data A1,A2,A3,A4, each at stb+1 with ack; o_empty=1 at the end.
- Level 2, simultaneous push and pop for 6 cycles -> level stays 2; data returns in FIFO order across the pointer wrap.
- Empty, simultaneous push 0x77 and pop -> pop not acked, o_underflow=1, level becomes 1; pop in the next cycle -> 0x77 with ack.
- AFULL_LVL=3, AEMPTY_LVL=1: step the level 0..4..0 -> o_aempty high at levels 0-1, o_afull high at levels 3-4.
- Level 3 with o_overflow set: pulse i_flush together with a push -> next cycle level=0, o_empty=1, o_overflow=0, no push ack. Assert i_reset_n low mid-pop -> acks drop immediately.
